execute_cycle: RTL and testbench
================================

// Module: execute_cycle
// PURPOSE
//  Execute stage of the 5-stage RISC-V pipelined core: consumes the E-stage bundle that decode_cycle registers.
//  Sequence: operand forwarding -> ALU -> branch resolution -> EX/MEM pipeline register -> M-stage bundle.
//  Sits between decode_cycle and memory_cycle; returns PCSrcE/PCTargetE to fetch_cycle.
// PARAMETERS
//  XLEN      32  datapath width (the core is RV32; only 32 is supported)
//  REG_AW    5   register address width
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-low
//  RegWriteE    in   1      register-file write enable, from decode_cycle
//  ALUSrcE      in   1      ALU operand B select: 1 = Imm_Ext_E, 0 = forwarded RD2
//  MemWriteE    in   1      data-memory write enable, from decode_cycle
//  ResultSrcE   in   1      result select: 1 = memory load, 0 = ALU result
//  BranchE      in   1      instruction is a beq
//  ALUControlE  in   3      ALU operation code
//  RD1_E,RD2_E  in   32     register-file read data
//  Imm_Ext_E    in   32     sign-extended immediate
//  RD_E         in   5      destination register
//  PCE,PCPlus4E in   32     PC of the instruction, and PC+4
//  ResultW      in   32     write-back result (forwarding source)
//  ALUResultM_fb in  32     M-stage ALU result (forwarding source)
//  ForwardAE,ForwardBE in 2 forwarding select from the hazard unit
//  StallM       in   1      hold the EX/MEM register
//  FlushM       in   1      insert a bubble into M
//  PCSrcE       out  1      branch taken (combinational)
//  PCTargetE    out  32     branch target (combinational)
//  RegWriteM,MemWriteM,ResultSrcM out 1   registered control
//  RD_M         out  5      registered destination register
//  ALUResultM,WriteDataM,PCPlus4M out 32  registered data
// BEHAVIOUR
//  Forwarding muxes: 00 = RD*_E, 01 = ResultW, 10 = ALUResultM_fb, 11 = RD*_E.
//   SrcAE = fwdA.  WriteDataE = fwdB.  SrcBE = ALUSrcE ? Imm_Ext_E : fwdB.
//  ALU operations:
//   000 add; 001 sub; 010 and; 011 or; 101 slt (signed, result 1/0).
//   Any other code yields 32'h0.  Add/sub wrap modulo 2^32; no overflow flag.
//  Zero flag and branch resolution:
//   ZeroE = (ALUResult == 0).  PCSrcE = BranchE & ZeroE.
//   PCTargetE = PCE + Imm_Ext_E, wrapping modulo 2^32.
//   PCSrcE/PCTargetE are driven every cycle, with no latency.
//  EX/MEM register: one-cycle latency, updated on posedge clk. Priority order:
//   !rst   -> all M outputs cleared to 0.
//   FlushM -> RegWriteM = MemWriteM = ResultSrcM = 0, RD_M = 0; data fields are don't-care, driven 0.
//   StallM -> all M outputs hold their current value.
//   else   -> capture the E-stage values.
//  Simultaneous FlushM & StallM: the flush wins.
//  Reset in mid-stream drops the in-flight instruction. PCSrcE still follows its inputs during reset.
//  RD_E == 0 with RegWriteE = 1 is propagated unchanged; the register file ignores writes to x0.
// CONFIGURATION
//  EXEC_FORWARDING_EN
//   Defined: forwarding muxes as above.
//   Undefined: fwdA = RD1_E, fwdB = RD2_E. ForwardAE, ForwardBE, ResultW and ALUResultM_fb stay as ports but are ignored.
// TESTING
//  1. rst = 0 for 2 cycles -> every M output reads 0. PCSrcE = 0 while BranchE = 0.
//  2. addi: RD1 = 5, Imm = 15, ALUSrc = 1, ALUCtl = 000, RD_E = 15
//     -> next cycle ALUResultM = 20, RD_M = 15, RegWriteM = 1.
//  3. beq: RD1 = RD2 = 7, ALUCtl = 001, BranchE = 1, PCE = 0x10, Imm = 0xFFFFFFF8
//     -> same cycle PCSrcE = 1, PCTargetE = 0x08.
//  4. slt: RD1 = 0xFFFFFFFF, RD2 = 1, ALUCtl = 101 -> ALUResultM = 1.
//     sub: 0 - 1 -> ALUResultM = 0xFFFFFFFF (wrap).
//  5. Forwarding (macro defined): ForwardAE = 10, ALUResultM_fb = 0x100, RD1 = 0, Imm = 4, add -> ALUResultM = 0x104.
//     ForwardBE = 01, ResultW = 0xAB, MemWriteE = 1 -> WriteDataM = 0xAB.
//     Macro undefined: same stimulus -> ALUResultM = 4.
//  6. StallM = 1 for 2 cycles -> M outputs frozen.
//     FlushM = 1 together with StallM = 1 -> RegWriteM = MemWriteM = 0, RD_M = 0.
//     Synchronous rst = 0 mid-stream -> all M outputs are 0 on the next edge.

Source files
------------

// File: rtl/execute_cycle_if.sv
// execute_cycle_if: E-stage bundle and hazard controls in, M-stage bundle and branch resolution out.
interface execute_cycle_if;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [4:0]  RD_E;
   logic [31:0] ResultW, ALUResultM_fb;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallM, FlushM;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   modport master (
      output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, RD1_E, RD2_E,
             Imm_Ext_E, PCE, PCPlus4E, RD_E, ResultW, ALUResultM_fb, ForwardAE, ForwardBE,
             StallM, FlushM,
      input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM,
             WriteDataM, PCPlus4M
   );
   modport slave (
      input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, RD1_E, RD2_E,
             Imm_Ext_E, PCE, PCPlus4E, RD_E, ResultW, ALUResultM_fb, ForwardAE, ForwardBE,
             StallM, FlushM,
      output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM,
             WriteDataM, PCPlus4M
   );
endinterface

// File: rtl/execute_cycle.sv
// execute_cycle: RV32 execute stage (forwarding, ALU, beq resolution, EX/MEM register).
// Define EXEC_FORWARDING_EN to enable the operand forwarding muxes.
module execute_cycle (
   input logic             clk,
   input logic             rst,
   execute_cycle_if.slave  bus
);
   typedef struct packed {
      logic        rw, mw, rs;
      logic [4:0]  rd;
      logic [31:0] alu, wd, pc4;
   } m_t;
   logic [31:0] fwd_a, fwd_b, src_b, alu_res;
   m_t m_q, m_d;
`ifdef EXEC_FORWARDING_EN
   assign fwd_a = bus.ForwardAE == 2'b01 ? bus.ResultW :
                  bus.ForwardAE == 2'b10 ? bus.ALUResultM_fb : bus.RD1_E;
   assign fwd_b = bus.ForwardBE == 2'b01 ? bus.ResultW :
                  bus.ForwardBE == 2'b10 ? bus.ALUResultM_fb : bus.RD2_E;
`else
   logic unused_fwd;
   assign unused_fwd = ^{bus.ForwardAE, bus.ForwardBE, bus.ResultW, bus.ALUResultM_fb};
   assign fwd_a = bus.RD1_E;
   assign fwd_b = bus.RD2_E;
`endif
   assign src_b   = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
   assign alu_res = bus.ALUControlE == 3'b000 ? fwd_a + src_b :
                    bus.ALUControlE == 3'b001 ? fwd_a - src_b :
                    bus.ALUControlE == 3'b010 ? fwd_a & src_b :
                    bus.ALUControlE == 3'b011 ? fwd_a | src_b :
                    bus.ALUControlE == 3'b101 ? {31'b0, $signed(fwd_a) < $signed(src_b)} : '0;
   assign bus.PCSrcE    = bus.BranchE & (alu_res == '0);
   assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
   // Flush beats stall so a bubble can always be inserted into a held stage.
   always_comb begin
      m_d = m_q;
      if (bus.FlushM)
         m_d = '0;
      else if (!bus.StallM)
         m_d = {bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, bus.RD_E, alu_res, fwd_b, bus.PCPlus4E};
   end
   always_ff @(posedge clk) begin
      if (!rst)
         m_q <= '0;
      else
         m_q <= m_d;
   end
   assign bus.RegWriteM  = m_q.rw;
   assign bus.MemWriteM  = m_q.mw;
   assign bus.ResultSrcM = m_q.rs;
   assign bus.RD_M       = m_q.rd;
   assign bus.ALUResultM = m_q.alu;
   assign bus.WriteDataM = m_q.wd;
   assign bus.PCPlus4M   = m_q.pc4;
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed stimulus with an arithmetic reference model checked every cycle.
module tb_execute_cycle;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   valid = 1'b0;
   execute_cycle_if bus ();
   execute_cycle dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   logic        e_rw, e_mw, e_rs;
   logic [4:0]  e_rd;
   logic [31:0] e_alu, e_wd, e_pc4;
   function automatic logic [31:0] opnd(logic [1:0] sel, logic [31:0] rd);
`ifdef EXEC_FORWARDING_EN
      if (sel == 2'd1) return bus.ResultW;
      if (sel == 2'd2) return bus.ALUResultM_fb;
`endif
      return rd;
   endfunction
   function automatic logic [31:0] ref_alu();
      logic [31:0] a, b;
      a = opnd(bus.ForwardAE, bus.RD1_E);
      b = bus.ALUSrcE ? bus.Imm_Ext_E : opnd(bus.ForwardBE, bus.RD2_E);
      case (bus.ALUControlE)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask
   always @(posedge clk) begin
      valid <= 1'b1;
      if (!rst || bus.FlushM)
         {e_rw, e_mw, e_rs, e_rd, e_alu, e_wd, e_pc4} = '0;
      else if (!bus.StallM)
         {e_rw, e_mw, e_rs, e_rd, e_alu, e_wd, e_pc4} =
            {bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, bus.RD_E, ref_alu(),
             opnd(bus.ForwardBE, bus.RD2_E), bus.PCPlus4E};
   end
   always @(negedge clk) if (valid) begin
      chk("PCSrcE", 32'(bus.PCSrcE), 32'(bus.BranchE && ref_alu() == 0));
      chk("PCTargetE", bus.PCTargetE, bus.PCE + bus.Imm_Ext_E);
      chk("RegWriteM", 32'(bus.RegWriteM), 32'(e_rw));
      chk("MemWriteM", 32'(bus.MemWriteM), 32'(e_mw));
      chk("ResultSrcM", 32'(bus.ResultSrcM), 32'(e_rs));
      chk("RD_M", 32'(bus.RD_M), 32'(e_rd));
      chk("ALUResultM", bus.ALUResultM, e_alu);
      chk("WriteDataM", bus.WriteDataM, e_wd);
      chk("PCPlus4M", bus.PCPlus4M, e_pc4);
   end
   task automatic clr();
      {bus.RegWriteE, bus.ALUSrcE, bus.MemWriteE, bus.ResultSrcE, bus.BranchE} = '0;
      bus.ALUControlE = '0;
      {bus.RD1_E, bus.RD2_E, bus.Imm_Ext_E, bus.PCE, bus.PCPlus4E} = '0;
      bus.RD_E = '0;
      {bus.ResultW, bus.ALUResultM_fb} = '0;
      {bus.ForwardAE, bus.ForwardBE} = '0;
      {bus.StallM, bus.FlushM} = '0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [31:0] held;
      rst = 1'b0;
      clr();
      tick();
      tick();
      chk("rst_alu", bus.ALUResultM, 32'd0);
      chk("rst_rw", 32'(bus.RegWriteM), 32'd0);
      chk("rst_pc4", bus.PCPlus4M, 32'd0);
      chk("rst_pcsrc", 32'(bus.PCSrcE), 32'd0);
      rst = 1'b1;
      bus.RD1_E = 32'd5; bus.Imm_Ext_E = 32'd15; bus.ALUSrcE = 1'b1;
      bus.RD_E = 5'd15; bus.RegWriteE = 1'b1; bus.PCPlus4E = 32'h44;
      tick();
      chk("addi_alu", bus.ALUResultM, 32'd20);
      chk("addi_rd", 32'(bus.RD_M), 32'd15);
      chk("addi_rw", 32'(bus.RegWriteM), 32'd1);
      clr();
      bus.RD1_E = 32'd7; bus.RD2_E = 32'd7; bus.ALUControlE = 3'd1; bus.BranchE = 1'b1;
      bus.PCE = 32'h10; bus.Imm_Ext_E = 32'hFFFF_FFF8;
      #1;
      chk("beq_pcsrc", 32'(bus.PCSrcE), 32'd1);
      chk("beq_target", bus.PCTargetE, 32'h8);
      tick();
      clr();
      bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'd1; bus.ALUControlE = 3'd5;
      tick();
      chk("slt", bus.ALUResultM, 32'd1);
      bus.RD1_E = 32'd0; bus.ALUControlE = 3'd1;
      tick();
      chk("sub_wrap", bus.ALUResultM, 32'hFFFF_FFFF);
      for (int i = 0; i < 8; i++) begin
         bus.ALUControlE = 3'(i);
         bus.RD1_E = 32'hF0F0_1234; bus.RD2_E = 32'h0FF0_8765;
         bus.BranchE = 1'b1; bus.RD_E = 5'(i + 1); bus.PCPlus4E = 32'(i * 4);
         tick();
      end
      chk("or_lit", bus.ALUResultM, 32'd0);
      clr();
      bus.ForwardAE = 2'b10; bus.ALUResultM_fb = 32'h100; bus.Imm_Ext_E = 32'd4;
      bus.ALUSrcE = 1'b1; bus.ForwardBE = 2'b01; bus.ResultW = 32'hAB;
      bus.RD2_E = 32'h55; bus.MemWriteE = 1'b1; bus.RD_E = 5'd2;
      tick();
`ifdef EXEC_FORWARDING_EN
      chk("fwd_alu", bus.ALUResultM, 32'h104);
      chk("fwd_wd", bus.WriteDataM, 32'hAB);
`else
      chk("nofwd_alu", bus.ALUResultM, 32'd4);
      chk("nofwd_wd", bus.WriteDataM, 32'h55);
`endif
      held = bus.ALUResultM;
      bus.ForwardAE = 2'b11; bus.RD1_E = 32'h20; bus.ForwardBE = 2'b11;
      tick();
      chk("fwd11_alu", bus.ALUResultM, 32'h24);
      bus.StallM = 1'b1; bus.RD1_E = 32'h999; bus.RD_E = 5'd7;
      tick();
      tick();
      chk("stall_alu", bus.ALUResultM, 32'h24);
      chk("stall_rd", 32'(bus.RD_M), 32'd2);
      bus.FlushM = 1'b1; bus.RegWriteE = 1'b1;
      tick();
      chk("flush_rw", 32'(bus.RegWriteM), 32'd0);
      chk("flush_mw", 32'(bus.MemWriteM), 32'd0);
      chk("flush_rd", 32'(bus.RD_M), 32'd0);
      clr();
      bus.RegWriteE = 1'b1; bus.RD_E = 5'd0; bus.RD1_E = held; bus.PCPlus4E = 32'h80;
      tick();
      chk("x0_rw", 32'(bus.RegWriteM), 32'd1);
      bus.RD_E = 5'd3; bus.RD1_E = 32'd9; bus.RD2_E = 32'd9; bus.ALUControlE = 3'd1;
      bus.BranchE = 1'b1;
      rst = 1'b0;
      #1;
      chk("rst_pcsrc_live", 32'(bus.PCSrcE), 32'd1);
      tick();
      chk("midrst_rw", 32'(bus.RegWriteM), 32'd0);
      chk("midrst_pc4", bus.PCPlus4M, 32'd0);
      rst = 1'b1;
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
